// File: rtl/fft_stage_sequencer.sv
// Walks the FFT butterfly engine through every group of every stage via req/ack,
// emitting per-group and per-stage strobes. Define FFT_STAGE_GAP_EN for a one-cycle bubble between stages.
module fft_stage_sequencer #(
    parameter int unsigned NUM_GROUPS = 16,
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned GW         = 5,
    parameter int unsigned SW         = 3
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          start,
    input  logic          group_ack,
    output logic          group_req,
    output logic [GW-1:0] group_index,
    output logic [SW-1:0] stage_index,
    output logic          iteration_strobe,
    output logic          stage_strobe,
    output logic          busy,
    output logic          fft_done
);

    localparam logic [GW-1:0] LAST_GROUP = GW'(NUM_GROUPS - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

`ifdef FFT_STAGE_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2, DONE = 2'd3} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd3} state_e;
`endif

    state_e        state_q, state_d;
    logic [GW-1:0] group_index_q, group_index_d;
    logic [SW-1:0] stage_index_q, stage_index_d;
    logic          group_req_q, group_req_d;
    logic          iteration_strobe_q, iteration_strobe_d;
    logic          stage_strobe_q, stage_strobe_d;
    logic          busy_q, busy_d;
    logic          fft_done_q, fft_done_d;
    logic          handshake;

    assign handshake = group_req_q && group_ack;

    // Next-state and next-output logic; every output is the registered image of its _d value.
    always_comb begin
        state_d            = state_q;
        group_index_d      = group_index_q;
        stage_index_d      = stage_index_q;
        group_req_d        = 1'b0;
        iteration_strobe_d = 1'b0;
        stage_strobe_d     = 1'b0;
        busy_d             = 1'b0;
        fft_done_d         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = ISSUE;
                    group_index_d = '0;
                    stage_index_d = '0;
                    group_req_d   = 1'b1;
                    busy_d        = 1'b1;
                end
            end
            ISSUE: begin
                group_req_d = 1'b1;
                busy_d      = 1'b1;
                if (handshake) begin
                    iteration_strobe_d = 1'b1;
                    if (group_index_q != LAST_GROUP) begin
                        group_index_d = group_index_q + GW'(1);
                    end else begin
                        stage_strobe_d = 1'b1;
                        if (stage_index_q != LAST_STAGE) begin
                            group_index_d = '0;
                            stage_index_d = stage_index_q + SW'(1);
`ifdef FFT_STAGE_GAP_EN
                            state_d     = GAP;
                            group_req_d = 1'b0;
`endif
                        end else begin
                            // Indices stay on the final group until IDLE clears them.
                            state_d     = DONE;
                            group_req_d = 1'b0;
                            fft_done_d  = 1'b1;
                        end
                    end
                end
            end
`ifdef FFT_STAGE_GAP_EN
            GAP: begin
                state_d     = ISSUE;
                group_req_d = 1'b1;
                busy_d      = 1'b1;
            end
`endif
            DONE: begin
                state_d       = IDLE;
                group_index_d = '0;
                stage_index_d = '0;
            end
            default: begin
                state_d       = IDLE;
                group_index_d = '0;
                stage_index_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q            <= IDLE;
            group_index_q      <= '0;
            stage_index_q      <= '0;
            group_req_q        <= 1'b0;
            iteration_strobe_q <= 1'b0;
            stage_strobe_q     <= 1'b0;
            busy_q             <= 1'b0;
            fft_done_q         <= 1'b0;
        end else begin
            state_q            <= state_d;
            group_index_q      <= group_index_d;
            stage_index_q      <= stage_index_d;
            group_req_q        <= group_req_d;
            iteration_strobe_q <= iteration_strobe_d;
            stage_strobe_q     <= stage_strobe_d;
            busy_q             <= busy_d;
            fft_done_q         <= fft_done_d;
        end
    end

    assign group_req        = group_req_q;
    assign group_index      = group_index_q;
    assign stage_index      = stage_index_q;
    assign iteration_strobe = iteration_strobe_q;
    assign stage_strobe     = stage_strobe_q;
    assign busy             = busy_q;
    assign fft_done         = fft_done_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer (default parameters: 16 groups x 5 stages).
// Expectations follow FFT_STAGE_GAP_EN when it is defined for the build.
module tb_fft_stage_sequencer;

`ifdef FFT_STAGE_GAP_EN
    localparam int GAPS    = 4;
    localparam logic [4:0] EXP_G22 = 5'd4;
`else
    localparam int GAPS    = 0;
    localparam logic [4:0] EXP_G22 = 5'd5;
`endif
    localparam int EXP_DONE = 81 + GAPS;

    logic       clk;
    logic       n_reset;
    logic       start;
    logic       group_ack;
    logic       group_req;
    logic [4:0] group_index;
    logic [2:0] stage_index;
    logic       iteration_strobe;
    logic       stage_strobe;
    logic       busy;
    logic       fft_done;
    logic [12:0] outs;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       req;
        logic       ack;
        logic       it;
        logic       st;
        logic       done;
        logic       busy;
        logic [4:0] gi;
        logic [2:0] si;
    } obs_t;

    obs_t trace[$];

    fft_stage_sequencer #(
        .NUM_GROUPS(16), .NUM_STAGES(5), .GW(5), .SW(3)
    ) dut (
        .clk             (clk),
        .n_reset         (n_reset),
        .start           (start),
        .group_ack       (group_ack),
        .group_req       (group_req),
        .group_index     (group_index),
        .stage_index     (stage_index),
        .iteration_strobe(iteration_strobe),
        .stage_strobe    (stage_strobe),
        .busy            (busy),
        .fft_done        (fft_done)
    );

    assign outs = {group_req, group_index, stage_index, iteration_strobe, stage_strobe, busy, fft_done};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t sample();
        obs_t o;
        o.req  = group_req;
        o.ack  = 1'b0;
        o.it   = iteration_strobe;
        o.st   = stage_strobe;
        o.done = fft_done;
        o.busy = busy;
        o.gi   = group_index;
        o.si   = stage_index;
        return o;
    endfunction

    // Drives one transform and records one observation per cycle; trace[c] is cycle c after start.
    task automatic capture(input int ack_period, input int restart_cyc, input int max_cyc);
        obs_t o;
        trace.delete();
        @(posedge clk); #1;
        start     = 1'b1;
        group_ack = 1'b1;
        o = sample(); o.ack = group_ack; trace.push_back(o);
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            start     = (c == restart_cyc);
            group_ack = ((c % ack_period) == 0);
            o = sample(); o.ack = group_ack; trace.push_back(o);
            if (!o.busy) break;
        end
        start     = 1'b0;
        group_ack = 1'b0;
    endtask

    task automatic test_reset();
        n_reset = 1'b1; start = 1'b0; group_ack = 1'b0;
        #2 n_reset = 1'b0;
        #1;
        n_cmp++;
        if (outs !== 13'd0) begin n_bad++; $display("FAIL reset_async outs=%b required=0", outs); end
        start = 1'b1; group_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (outs !== 13'd0) begin n_bad++; $display("FAIL reset_held outs=%b required=0", outs); end
        start = 1'b0; group_ack = 1'b0;
        @(negedge clk); n_reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (outs !== 13'd0) begin n_bad++; $display("FAIL reset_release outs=%b required=0", outs); end
    endtask

    task automatic test_continuous();
        int it = 0, st = 0, dn = 0, done_c = -1, low_c = -1, gap = 0;
        obs_t o, p;
        capture(1, -1, 200);
        n_cmp++;
        if (trace[1].req !== 1'b1 || trace[1].busy !== 1'b1 || trace[1].gi !== 5'd0 || trace[1].si !== 3'd0) begin
            n_bad++; $display("FAIL first_req req=%b busy=%b gi=%0d si=%0d required 1 1 0 0",
                              trace[1].req, trace[1].busy, trace[1].gi, trace[1].si);
        end
        for (int c = 1; c < trace.size(); c++) begin
            o = trace[c]; p = trace[c-1];
            if (o.it) it++;
            if (o.st) st++;
            if (o.done) begin dn++; if (done_c < 0) done_c = c; end
            if (!o.busy && low_c < 0) low_c = c;
            if (o.st) begin
                n_cmp++;
                if (p.gi !== 5'd15) begin n_bad++; $display("FAIL stage_strobe_group cyc=%0d accepted=%0d required=15", c, p.gi); end
            end
            if (o.busy && !o.req && !o.done) begin
                gap++;
                n_cmp++;
                if (o.st !== 1'b1) begin n_bad++; $display("FAIL gap_after_stage cyc=%0d stage_strobe=%b required=1", c, o.st); end
            end
            if (o.done) begin
                n_cmp++;
                if (o.it !== 1'b1 || o.st !== 1'b1 || o.busy !== 1'b1) begin
                    n_bad++; $display("FAIL done_together it=%b st=%b busy=%b required 1 1 1", o.it, o.st, o.busy);
                end
            end
        end
        n_cmp++; if (it != 80) begin n_bad++; $display("FAIL cont_iterations got=%0d required=80", it); end
        n_cmp++; if (st != 5) begin n_bad++; $display("FAIL cont_stage_strobes got=%0d required=5", st); end
        n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL cont_done_pulses got=%0d required=1", dn); end
        n_cmp++; if (done_c != EXP_DONE) begin n_bad++; $display("FAIL cont_done_cycle got=%0d required=%0d", done_c, EXP_DONE); end
        n_cmp++; if (low_c != EXP_DONE + 1) begin n_bad++; $display("FAIL cont_busy_low got=%0d required=%0d", low_c, EXP_DONE + 1); end
        n_cmp++; if (gap != GAPS) begin n_bad++; $display("FAIL cont_gap_cycles got=%0d required=%0d", gap, GAPS); end
    endtask

    task automatic test_ack_throttle();
        int it = 0, dn = 0;
        logic [4:0] exp_g = 5'd0;
        logic [2:0] exp_s = 3'd0;
        logic hs;
        obs_t o, p;
        capture(3, -1, 400);
        for (int c = 1; c < trace.size(); c++) begin
            o = trace[c]; p = trace[c-1];
            hs = p.req && p.ack;
            n_cmp++;
            if (o.it !== hs) begin n_bad++; $display("FAIL thr_strobe cyc=%0d got=%b required=%b", c, o.it, hs); end
            if (o.done) dn++;
            if (o.it) begin
                it++;
                if (exp_g == 5'd15) begin exp_g = 5'd0; exp_s = exp_s + 3'd1; end
                else exp_g = exp_g + 5'd1;
            end
            if (o.req) begin
                n_cmp++;
                if (o.gi !== exp_g || o.si !== exp_s) begin
                    n_bad++; $display("FAIL thr_index cyc=%0d got=%0d/%0d required=%0d/%0d", c, o.si, o.gi, exp_s, exp_g);
                end
            end
            if (p.req && !p.ack && o.req) begin
                n_cmp++;
                if (o.gi !== p.gi || o.si !== p.si) begin
                    n_bad++; $display("FAIL thr_hold cyc=%0d got=%0d/%0d required=%0d/%0d", c, o.si, o.gi, p.si, p.gi);
                end
            end
        end
        n_cmp++; if (it != 80) begin n_bad++; $display("FAIL thr_iterations got=%0d required=80", it); end
        n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL thr_done_pulses got=%0d required=1", dn); end
    endtask

    task automatic test_start_ignored();
        int it = 0, dn = 0, done_c = -1;
        capture(1, 20, 200);
        for (int c = 1; c < trace.size(); c++) begin
            if (trace[c].it) it++;
            if (trace[c].done) begin dn++; if (done_c < 0) done_c = c; end
        end
        n_cmp++;
        if (trace[22].gi !== EXP_G22 || trace[22].si !== 3'd1) begin
            n_bad++; $display("FAIL restart_index got=%0d/%0d required=1/%0d", trace[22].si, trace[22].gi, EXP_G22);
        end
        n_cmp++; if (it != 80) begin n_bad++; $display("FAIL restart_iterations got=%0d required=80", it); end
        n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL restart_done_pulses got=%0d required=1", dn); end
        n_cmp++; if (done_c != EXP_DONE) begin n_bad++; $display("FAIL restart_done_cycle got=%0d required=%0d", done_c, EXP_DONE); end
    endtask

    task automatic test_mid_reset();
        bit hit = 1'b0;
        int dn = 0, it = 0;
        @(posedge clk); #1;
        start = 1'b1; group_ack = 1'b1;
        for (int c = 1; c <= 120 && !hit; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (fft_done) dn++;
            if (group_req && stage_index == 3'd2 && group_index == 5'd7) hit = 1'b1;
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL abort_reach_s2g7 got=0 required=1"); end
        n_reset = 1'b0;
        #1;
        n_cmp++; if (outs !== 13'd0) begin n_bad++; $display("FAIL abort_async_clear outs=%b required=0", outs); end
        n_cmp++; if (dn != 0) begin n_bad++; $display("FAIL abort_early_done got=%0d required=0", dn); end
        @(negedge clk); n_reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (outs !== 13'd0) begin n_bad++; $display("FAIL abort_no_done outs=%b required=0", outs); end
        start = 1'b1; group_ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (group_req !== 1'b1 || busy !== 1'b1 || group_index !== 5'd0 || stage_index !== 3'd0 || iteration_strobe !== 1'b0) begin
            n_bad++; $display("FAIL abort_restart req=%b busy=%b gi=%0d si=%0d it=%b required 1 1 0 0 0",
                              group_req, busy, group_index, stage_index, iteration_strobe);
        end
        for (int c = 0; c < 120 && busy; c++) begin
            @(posedge clk); #1;
            if (iteration_strobe) it++;
            if (fft_done) dn++;
        end
        group_ack = 1'b0;
        n_cmp++; if (it != 80 || dn != 1) begin n_bad++; $display("FAIL abort_rerun it=%0d done=%0d required 80 1", it, dn); end
    endtask

    task automatic test_idle_ack();
        @(posedge clk); #1;
        start = 1'b0; group_ack = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (outs !== 13'd0) begin n_bad++; $display("FAIL idle_ack cyc=%0d outs=%b required=0", c, outs); end
        end
        group_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_ack();
        test_continuous();
        test_ack_throttle();
        test_start_ignored();
        test_mid_reset();
        test_idle_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
